rggen_apb_register_file: RTL and testbench
==========================================

Name: rggen_apb_register_file

Overview:
- Parametrised APB register file and successor to the hand-assembled per-register blocks.
- Holds NUM_REGISTERS registers of DATA_WIDTH bits. Each bit is typed RW, RO or W1C by mask parameters.
- Includes an APB slave FSM with configurable wait states, byte strobes and an interrupt output built from W1C status bits.
- Sits between the APB fabric and block-level control/status logic.

Parameters:
- ADDRESS_WIDTH, 8: width of apb_paddr (byte address).
- DATA_WIDTH, 32: register width; must be 8, 16, 32 or 64.
- NUM_REGISTERS, 4: number of registers. Register i is at byte address i*(DATA_WIDTH/8).
- WAIT_CYCLES, 0: extra wait states inserted before apb_pready.
- RW_MASK, all ones (NUM_REGISTERS*DATA_WIDTH bits): 1 = bit is RW.
- W1C_MASK, all zeros (same width): 1 = bit is W1C status. Overrides RW_MASK.
- INITIAL_VALUE, all zeros (same width): reset value of RW bits.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- apb_psel  input  1  APB select
- apb_penable  input  1  APB enable
- apb_pwrite  input  1  1 = write
- apb_paddr  input  ADDRESS_WIDTH  byte address
- apb_pwdata  input  DATA_WIDTH  write data
- apb_pstrb  input  DATA_WIDTH/8  byte strobes
- apb_pready  output  1  transfer complete
- apb_prdata  output  DATA_WIDTH  read data
- apb_pslverr  output  1  error response
- o_value  output  NUM_REGISTERS*DATA_WIDTH  current RW/W1C bit values; RO positions read 0
- i_value  input  NUM_REGISTERS*DATA_WIDTH  RO bit sources
- i_set  input  NUM_REGISTERS*DATA_WIDTH  per-bit set pulses for W1C bits; ignored at other positions
- o_irq  output  1  OR of all W1C bits

Behaviour:
- Reset (rst=1, async):
  - FSM goes to IDLE; apb_pready=0, apb_prdata=0, apb_pslverr=0.
  - RW bits load INITIAL_VALUE; W1C bits clear to 0; o_irq=0.
  - A transfer in progress when reset asserts is abandoned and has no effect.
- FSM states: IDLE, WAIT, RESP.
  - IDLE -> WAIT when apb_psel & apb_penable. The wait counter loads WAIT_CYCLES.
  - WAIT decrements the counter. At 0 it goes to RESP.
  - RESP drives registered apb_pready=1 for exactly one cycle, then returns to IDLE.
  - Latency: apb_pready rises WAIT_CYCLES+2 cycles after the first access-phase cycle.
- Address decode:
  - index = apb_paddr >> log2(DATA_WIDTH/8).
  - Low address bits are ignored.
  - Addresses with index >= NUM_REGISTERS are unmapped.
- Write commit:
  - Occurs on the clock edge that ends RESP, for mapped addresses only.
  - Only strobed bytes are affected.
  - RW bits take apb_pwdata.
  - W1C bits with written 1 clear; written 0 has no effect.
  - RO bits ignore writes.
- Read:
  - apb_prdata is registered on entry to RESP.
  - Per bit: RW and W1C bits return the stored value; RO bits return i_value sampled that cycle.
  - apb_prdata is 0 outside RESP and for unmapped addresses.
- W1C set:
  - i_set=1 sets the bit on any cycle.
  - If set and W1C-clear hit the same edge, set wins and the bit stays 1.
- o_irq is registered. It reflects the W1C state one cycle after the change.
- If apb_psel drops before RESP (protocol violation), the FSM still completes the sequence but the write is not committed.

Optional Feature:
- Macro: RGGEN_APB_REGISTER_FILE_PSLVERR_EN.
- Defined: apb_pslverr=1 in RESP for unmapped addresses, or when apb_pstrb=0 on a write. No state changes for such transfers.
- Undefined: apb_pslverr is tied 0. Unmapped accesses read 0 and writes are silently dropped.

Test Plan:
- Reset, then read all 4 registers with default parameters -> prdata 0x00000000 each; apb_pready high exactly one cycle, 2 cycles after penable.
- Write 0xDEADBEEF to 0x04 with pstrb=4'b0101 -> readback 0x00AD00EF; o_value[63:32]=0x00AD00EF.
- WAIT_CYCLES=3 -> pready rises 5 cycles after penable. Assert rst during WAIT -> pready stays 0 and the write is not committed.
- W1C_MASK reg 2 bit 0: pulse i_set[64] -> o_irq=1 next cycle. Write 0x1 to 0x08 with i_set[64] high on the commit edge -> bit stays 1. Write 0x1 again without i_set -> bit 0 and o_irq fall.
- RW_MASK reg 3 = 0, i_value[127:96]=0xCAFE0001 -> read 0x0C returns 0xCAFE0001; write 0xFFFFFFFF then read -> still 0xCAFE0001.
- With PSLVERR_EN: write 0x10 (unmapped) -> pslverr=1 and no register change. Without the macro: pslverr=0 and prdata=0.

Source files
------------

// File: rtl/rggen_apb_register_file.sv
// rggen_apb_register_file
//   APB slave holding NUM_REGISTERS registers of DATA_WIDTH bits.
//   Each bit is RW, RO or W1C as selected by RW_MASK / W1C_MASK
//   (W1C_MASK takes precedence). o_irq is the registered OR of all W1C bits.
//   Optional macro RGGEN_APB_REGISTER_FILE_PSLVERR_EN enables apb_pslverr
//   for unmapped addresses and zero-strobe writes.
//   Handshake: a transfer starts when apb_psel & apb_penable are seen in
//   IDLE; apb_pready is high for exactly one cycle (RESP) and the master
//   must hold address, control and write data until that cycle ends.
module rggen_apb_register_file #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGISTERS = 4,
   parameter int WAIT_CYCLES   = 0,
   parameter logic [NUM_REGISTERS*DATA_WIDTH-1:0] RW_MASK       = '1,
   parameter logic [NUM_REGISTERS*DATA_WIDTH-1:0] W1C_MASK      = '0,
   parameter logic [NUM_REGISTERS*DATA_WIDTH-1:0] INITIAL_VALUE = '0
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                apb_psel,
   input  logic                                apb_penable,
   input  logic                                apb_pwrite,
   input  logic [ADDRESS_WIDTH-1:0]            apb_paddr,
   input  logic [DATA_WIDTH-1:0]               apb_pwdata,
   input  logic [DATA_WIDTH/8-1:0]             apb_pstrb,
   output logic                                apb_pready,
   output logic [DATA_WIDTH-1:0]               apb_prdata,
   output logic                                apb_pslverr,
   output logic [NUM_REGISTERS*DATA_WIDTH-1:0] o_value,
   input  logic [NUM_REGISTERS*DATA_WIDTH-1:0] i_value,
   input  logic [NUM_REGISTERS*DATA_WIDTH-1:0] i_set,
   output logic                                o_irq
);

   localparam int BYTES    = DATA_WIDTH / 8;
   localparam int ADDR_LSB = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam int TOTAL_W  = NUM_REGISTERS * DATA_WIDTH;
   localparam int CNT_W    = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

   // Effective bit-type masks; W1C wins over RW, everything else is RO.
   localparam logic [TOTAL_W-1:0] RW_ONLY = RW_MASK & ~W1C_MASK;
   localparam logic [TOTAL_W-1:0] RO_MASK = ~(RW_MASK | W1C_MASK);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [CNT_W-1:0]         cnt;
   logic                     abort_q;
   logic                     pready_q;
   logic [DATA_WIDTH-1:0]    prdata_q;
   logic                     pslverr_q;
   logic                     irq_q;
   logic [TOTAL_W-1:0]       value_q;
   logic [TOTAL_W-1:0]       value_d;

   // FSM-decoded strobes
   logic                     start_xfer;
   logic                     load_resp;
   logic                     in_resp;

   // Address decode and transfer qualification
   logic [ADDRESS_WIDTH-1:0] index;
   logic                     mapped;
   logic                     xfer_err;
   logic                     commit;
   logic [DATA_WIDTH-1:0]    rd_data;
   logic [TOTAL_W-1:0]       wr_bits;
   logic [TOTAL_W-1:0]       wdata_rep;
   logic [TOTAL_W-1:0]       rw_next;
   logic [TOTAL_W-1:0]       w1c_next;

   assign index  = apb_paddr >> ADDR_LSB;
   assign mapped = (index < ADDRESS_WIDTH'(NUM_REGISTERS));

`ifdef RGGEN_APB_REGISTER_FILE_PSLVERR_EN
   assign xfer_err = !mapped || (apb_pwrite && (apb_pstrb == '0));
`else
   assign xfer_err = !mapped;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (apb_psel && apb_penable) state_next = ST_WAIT;
         ST_WAIT: if (cnt == '0) state_next = ST_RESP;
         ST_RESP: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM output decode
   always_comb begin
      start_xfer = 1'b0;
      load_resp  = 1'b0;
      in_resp    = 1'b0;
      case (state)
         ST_IDLE: start_xfer = apb_psel && apb_penable;
         ST_WAIT: load_resp  = (cnt == '0);
         ST_RESP: in_resp    = 1'b1;
         default: ;
      endcase
   end

   // Wait-state counter: loaded on start, counts down while in WAIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (start_xfer) begin
         cnt <= CNT_W'(WAIT_CYCLES);
      end else if ((state == ST_WAIT) && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // Remember a master that dropped psel mid-transfer so the write is suppressed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         abort_q <= 1'b0;
      end else if (start_xfer) begin
         abort_q <= 1'b0;
      end else if ((state == ST_WAIT) && !apb_psel) begin
         abort_q <= 1'b1;
      end
   end

   // Read mux: stored RW/W1C bits merged with live RO sources
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGISTERS; i++) begin
         if (index == ADDRESS_WIDTH'(i)) begin
            rd_data = value_q[i*DATA_WIDTH +: DATA_WIDTH]
                    | (i_value[i*DATA_WIDTH +: DATA_WIDTH] & RO_MASK[i*DATA_WIDTH +: DATA_WIDTH]);
         end
      end
   end

   // Response registers: loaded on entry to RESP, cleared when leaving it.
   // prdata is only loaded for reads; unmapped reads return 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
      end else if (load_resp) begin
         pready_q  <= 1'b1;
         prdata_q  <= (!apb_pwrite && mapped) ? rd_data : '0;
`ifdef RGGEN_APB_REGISTER_FILE_PSLVERR_EN
         pslverr_q <= xfer_err;
`else
         pslverr_q <= 1'b0;
`endif
      end else begin
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
      end
   end

   assign commit = in_resp && apb_psel && apb_pwrite && !abort_q && !xfer_err;

   // Next register value: strobed writes, W1C clears, set pulses (set wins)
   always_comb begin
      wr_bits   = '0;
      wdata_rep = '0;
      for (int i = 0; i < NUM_REGISTERS; i++) begin
         wdata_rep[i*DATA_WIDTH +: DATA_WIDTH] = apb_pwdata;
         for (int b = 0; b < BYTES; b++) begin
            if (commit && (index == ADDRESS_WIDTH'(i)) && apb_pstrb[b]) begin
               wr_bits[i*DATA_WIDTH + b*8 +: 8] = 8'hff;
            end
         end
      end
      rw_next  = (value_q & ~wr_bits) | (wdata_rep & wr_bits);
      w1c_next = (value_q & ~(wr_bits & wdata_rep)) | i_set;
      value_d  = (rw_next & RW_ONLY) | (w1c_next & W1C_MASK);
   end

   // Register storage; RO positions are never stored and stay 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= INITIAL_VALUE & RW_ONLY;
      end else begin
         value_q <= value_d;
      end
   end

   // Interrupt follows the stored W1C state one cycle later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |(value_q & W1C_MASK);
      end
   end

   assign apb_pready  = pready_q;
   assign apb_prdata  = prdata_q;
   assign apb_pslverr = pslverr_q;
   assign o_value     = value_q;
   assign o_irq       = irq_q;

endmodule

// File: tb/tb_rggen_apb_register_file.sv
// Directed bench for rggen_apb_register_file.
//   dut0: default parameters.
//   dut1: WAIT_CYCLES=3, reg2 bit0 W1C, reg3 fully RO, reg0 resets to 0x12345678.
//   Both share the APB bus except psel.
module tb_rggen_apb_register_file;

   logic         clk;
   logic         rst;
   logic         psel0;
   logic         psel1;
   logic         penable;
   logic         pwrite;
   logic [7:0]   paddr;
   logic [31:0]  pwdata;
   logic [3:0]   pstrb;

   logic         pready0, pready1;
   logic [31:0]  prdata0, prdata1;
   logic         pslverr0, pslverr1;
   logic [127:0] o_value0, o_value1;
   logic [127:0] i_value0, i_value1;
   logic [127:0] i_set0, i_set1;
   logic         irq0, irq1;

   int n_vec;
   int n_miss;
   logic set_on_resp;

   logic [31:0] rdata;
   logic        err;
   int          lat;
   logic        exp_err;

   rggen_apb_register_file dut0 (
      .clk(clk), .rst(rst),
      .apb_psel(psel0), .apb_penable(penable), .apb_pwrite(pwrite),
      .apb_paddr(paddr), .apb_pwdata(pwdata), .apb_pstrb(pstrb),
      .apb_pready(pready0), .apb_prdata(prdata0), .apb_pslverr(pslverr0),
      .o_value(o_value0), .i_value(i_value0), .i_set(i_set0), .o_irq(irq0)
   );

   rggen_apb_register_file #(
      .WAIT_CYCLES(3),
      .RW_MASK(128'h0000_0000_ffff_ffff_ffff_ffff_ffff_ffff),
      .W1C_MASK(128'h0000_0000_0000_0001_0000_0000_0000_0000),
      .INITIAL_VALUE(128'h0000_0000_0000_0000_0000_0000_1234_5678)
   ) dut1 (
      .clk(clk), .rst(rst),
      .apb_psel(psel1), .apb_penable(penable), .apb_pwrite(pwrite),
      .apb_paddr(paddr), .apb_pwdata(pwdata), .apb_pstrb(pstrb),
      .apb_pready(pready1), .apb_prdata(prdata1), .apb_pslverr(pslverr1),
      .o_value(o_value1), .i_value(i_value1), .i_set(i_set1), .o_irq(irq1)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One complete APB transfer on the selected DUT; returns data, error and
   // the number of cycles from the first access-phase cycle to pready.
   task automatic apb_xfer(input int which, input logic wr, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           output logic [31:0] rd, output logic er, output int lt);
      logic rdy;
      @(posedge clk); #1;
      if (which == 0) psel0 = 1'b1; else psel1 = 1'b1;
      pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1;
      lt = 0;
      rdy = 1'b0;
      forever begin
         @(negedge clk);
         rdy = (which == 0) ? pready0 : pready1;
         if (rdy || lt >= 40) break;
         @(posedge clk); #1;
         lt++;
      end
      if (!rdy) check_val("pready_timeout", {63'd0, rdy}, 64'd1);
      rd = (which == 0) ? prdata0 : prdata1;
      er = (which == 0) ? pslverr0 : pslverr1;
      if (set_on_resp) i_set1[64] = 1'b1;
      @(posedge clk); #1;
      i_set1 = '0;
      psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
      @(negedge clk);
      rdy = (which == 0) ? pready0 : pready1;
      check_val("pready_one_cycle", {63'd0, rdy}, 64'd0);
   endtask

   initial begin
      n_vec = 0; n_miss = 0; set_on_resp = 1'b0;
      psel0 = 0; psel1 = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0;
      i_value0 = '0; i_set0 = '0; i_set1 = '0;
      i_value1 = '0;
      i_value1[127:96] = 32'hcafe_0001;
`ifdef RGGEN_APB_REGISTER_FILE_PSLVERR_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      // reset state
      check_val("rst_pready", {63'd0, pready0}, 64'd0);
      check_val("rst_prdata", {32'd0, prdata0}, 64'd0);
      check_val("rst_pslverr", {63'd0, pslverr0}, 64'd0);
      check_val("rst_irq", {63'd0, irq1}, 64'd0);
      check_val("rst_value0", o_value0[63:0], 64'd0);
      check_val("rst_value1_r0", {32'd0, o_value1[31:0]}, 64'h1234_5678);

      // default reads, 2-cycle latency
      for (int i = 0; i < 4; i++) begin
         apb_xfer(0, 1'b0, 8'(i * 4), 32'd0, 4'hf, rdata, err, lat);
         check_val("dflt_read", {32'd0, rdata}, 64'd0);
         check_val("dflt_latency", 64'(lat), 64'd2);
      end

      // partial strobe write
      apb_xfer(0, 1'b1, 8'h04, 32'hdead_beef, 4'b0101, rdata, err, lat);
      apb_xfer(0, 1'b0, 8'h04, 32'd0, 4'hf, rdata, err, lat);
      check_val("strb_read", {32'd0, rdata}, 64'h00ad_00ef);
      check_val("strb_ovalue", {32'd0, o_value0[63:32]}, 64'h00ad_00ef);
      apb_xfer(0, 1'b0, 8'h05, 32'd0, 4'hf, rdata, err, lat);
      check_val("low_addr_ignored", {32'd0, rdata}, 64'h00ad_00ef);

      // full write to reg0 and reg3
      apb_xfer(0, 1'b1, 8'h00, 32'ha5a5_0f0f, 4'hf, rdata, err, lat);
      apb_xfer(0, 1'b1, 8'h0c, 32'h1357_9bdf, 4'hf, rdata, err, lat);
      apb_xfer(0, 1'b0, 8'h00, 32'd0, 4'hf, rdata, err, lat);
      check_val("full_read_r0", {32'd0, rdata}, 64'ha5a5_0f0f);
      apb_xfer(0, 1'b0, 8'h0c, 32'd0, 4'hf, rdata, err, lat);
      check_val("full_read_r3", {32'd0, rdata}, 64'h1357_9bdf);

      // unmapped write and read
      apb_xfer(0, 1'b1, 8'h10, 32'hffff_ffff, 4'hf, rdata, err, lat);
      check_val("unmapped_wr_err", {63'd0, err}, {63'd0, exp_err});
      check_val("unmapped_wr_lo", o_value0[63:0], 64'h00ad_00ef_a5a5_0f0f);
      check_val("unmapped_wr_hi", o_value0[127:64], 64'h1357_9bdf_0000_0000);
      apb_xfer(0, 1'b0, 8'h10, 32'd0, 4'hf, rdata, err, lat);
      check_val("unmapped_rd_data", {32'd0, rdata}, 64'd0);
      check_val("unmapped_rd_err", {63'd0, err}, {63'd0, exp_err});

      // zero-strobe write
      apb_xfer(0, 1'b1, 8'h08, 32'hffff_ffff, 4'h0, rdata, err, lat);
      check_val("nostrb_err", {63'd0, err}, {63'd0, exp_err});
      check_val("nostrb_value", {32'd0, o_value0[95:64]}, 64'd0);

      // wait states
      apb_xfer(1, 1'b0, 8'h00, 32'd0, 4'hf, rdata, err, lat);
      check_val("wait_latency", 64'(lat), 64'd5);
      check_val("wait_read_r0", {32'd0, rdata}, 64'h1234_5678);

      // W1C set pulse and interrupt
      @(posedge clk); #1 i_set1[64] = 1'b1;
      @(posedge clk); #1 i_set1 = '0;
      @(negedge clk);
      check_val("w1c_set_bit", {32'd0, o_value1[95:64]}, 64'd1);
      @(negedge clk);
      check_val("w1c_irq_rise", {63'd0, irq1}, 64'd1);
      apb_xfer(1, 1'b1, 8'h08, 32'h0, 4'hf, rdata, err, lat);
      apb_xfer(1, 1'b0, 8'h08, 32'd0, 4'hf, rdata, err, lat);
      check_val("w1c_write0_keep", {32'd0, rdata}, 64'd1);
      set_on_resp = 1'b1;
      apb_xfer(1, 1'b1, 8'h08, 32'h1, 4'hf, rdata, err, lat);
      set_on_resp = 1'b0;
      apb_xfer(1, 1'b0, 8'h08, 32'd0, 4'hf, rdata, err, lat);
      check_val("w1c_set_wins", {32'd0, rdata}, 64'd1);
      check_val("w1c_irq_held", {63'd0, irq1}, 64'd1);
      apb_xfer(1, 1'b1, 8'h08, 32'h1, 4'hf, rdata, err, lat);
      @(negedge clk);
      check_val("w1c_irq_fall", {63'd0, irq1}, 64'd0);
      apb_xfer(1, 1'b0, 8'h08, 32'd0, 4'hf, rdata, err, lat);
      check_val("w1c_cleared", {32'd0, rdata}, 64'd0);

      // RO register
      apb_xfer(1, 1'b0, 8'h0c, 32'd0, 4'hf, rdata, err, lat);
      check_val("ro_read", {32'd0, rdata}, 64'hcafe_0001);
      check_val("ro_ovalue", {32'd0, o_value1[127:96]}, 64'd0);
      apb_xfer(1, 1'b1, 8'h0c, 32'hffff_ffff, 4'hf, rdata, err, lat);
      apb_xfer(1, 1'b0, 8'h0c, 32'd0, 4'hf, rdata, err, lat);
      check_val("ro_after_write", {32'd0, rdata}, 64'hcafe_0001);

      // reset during WAIT abandons the write
      apb_xfer(1, 1'b1, 8'h00, 32'hffff_ffff, 4'hf, rdata, err, lat);
      check_val("pre_rst_value", {32'd0, o_value1[31:0]}, 64'hffff_ffff);
      @(posedge clk); #1;
      psel1 = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h0; pstrb = 4'hf; penable = 1'b0;
      @(posedge clk); #1 penable = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("in_wait_pready", {63'd0, pready1}, 64'd0);
      rst = 1'b1;
      psel1 = 1'b0; penable = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_val("rst_wait_pready", {63'd0, pready1}, 64'd0);
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_val("post_rst_pready", {63'd0, pready1}, 64'd0);
      end
      check_val("rst_no_commit", {32'd0, o_value1[31:0]}, 64'h1234_5678);
      apb_xfer(1, 1'b0, 8'h00, 32'd0, 4'hf, rdata, err, lat);
      check_val("rst_readback", {32'd0, rdata}, 64'h1234_5678);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
